// File: rtl/cnn_seq_pkg.sv
// Shared types and constants for the CNN layer sequencer.
package cnn_seq_pkg;

   // Layer sequencing FSM states; the encoding is what state_o exposes.
   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      CONV_START = 3'd1,
      CONV_WAIT  = 3'd2,
      POOL_START = 3'd3,
      POOL_WAIT  = 3'd4,
      FC_RUN     = 3'd5,
      DONE       = 3'd6,
      ERR        = 3'd7
   } state_e;

   // err_code values: which layer timed out
   localparam logic [1:0] ERR_NONE = 2'b00;
   localparam logic [1:0] ERR_CONV = 2'b01;
   localparam logic [1:0] ERR_POOL = 2'b10;
   localparam logic [1:0] ERR_FC   = 2'b11;

   // layer_en bit positions
   localparam int L_CONV = 0;
   localparam int L_POOL = 1;
   localparam int L_FC   = 2;

   // Search start points for layer_from
   localparam logic [1:0] FROM_CONV = 2'd0;
   localparam logic [1:0] FROM_POOL = 2'd1;
   localparam logic [1:0] FROM_FC   = 2'd2;

   // First enabled layer at or after 'from', or DONE when none is left.
   function automatic state_e layer_from(input logic [2:0] en, input logic [1:0] from);
      state_e s;
      s = DONE;
      if (from <= FROM_FC   && en[L_FC])   s = FC_RUN;
      if (from <= FROM_POOL && en[L_POOL]) s = POOL_START;
      if (from == FROM_CONV && en[L_CONV]) s = CONV_START;
      return s;
   endfunction

endpackage

// File: rtl/cnn_seq_timeout.sv
// Wait-state timeout counter. The count is the number of cycles already spent
// in the current wait state, so expired flags the TIMEOUT_CYCLES-th cycle.
module cnn_seq_timeout #(
   parameter int TIMEOUT_CYCLES = 1000,
   parameter int CNT_W          = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic run,
   output logic expired
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Clear wins; otherwise count while waiting, saturating at the last value
   always_comb begin
      cnt_d = cnt_q;
      if (clear)                    cnt_d = '0;
      else if (run && cnt_q != LAST) cnt_d = cnt_q + 1'b1;
   end

   // Counter register
   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign expired = run && (cnt_q == LAST);

endmodule

// File: rtl/cnn_layer_sequencer.sv
// Sequences conv -> pool (per channel) -> fc for one CNN layer run, with a
// per-layer completion timeout and abort.
module cnn_layer_sequencer
   import cnn_seq_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1000,
   parameter int CNT_W          = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       abort,
   input  logic [2:0] layer_en,
   input  logic [7:0] num_channels,
   output logic       conv_valid_in,
   input  logic       conv_valid_out,
   output logic       pool_valid_in,
   input  logic       pool_valid_out,
   output logic [7:0] ch_idx,
   output logic       pool_capture,
   output logic       fc_en,
   input  logic       fc_valid,
   output logic       busy,
   output logic       done,
   output logic       error,
   output logic [1:0] err_code,
   output logic [2:0] state_o
);

   state_e     state_q, state_d;
   logic [2:0] en_q, en_d;
   logic [7:0] count_q, count_d;
   logic [7:0] ch_q, ch_d;
   logic       error_q, error_d;
   logic [1:0] err_code_q, err_code_d;
   logic       in_wait, tmo_clear, tmo_expired;

   // Any state change restarts the count, so back-to-back wait states
   // (e.g. CONV_WAIT -> FC_RUN) each get a full timeout window.
   assign in_wait   = (state_q == CONV_WAIT) || (state_q == POOL_WAIT) || (state_q == FC_RUN);
   assign tmo_clear = (state_d != state_q);

   cnn_seq_timeout #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .CNT_W          (CNT_W)
   ) u_timeout (
      .clk     (clk),
      .rst     (rst),
      .clear   (tmo_clear),
      .run     (in_wait),
      .expired (tmo_expired)
   );

   // Next-state logic; completions beat timeout, abort beats both
   always_comb begin
      state_d    = state_q;
      en_d       = en_q;
      count_d    = count_q;
      ch_d       = ch_q;
      error_d    = error_q;
      err_code_d = err_code_q;
      unique case (state_q)
         IDLE: if (start) begin
            en_d       = layer_en;
            count_d    = (num_channels == 8'd0) ? 8'd1 : num_channels;
            ch_d       = 8'd0;
            error_d    = 1'b0;
            err_code_d = ERR_NONE;
            state_d    = layer_from(layer_en, FROM_CONV);
         end
         CONV_START: state_d = CONV_WAIT;
         CONV_WAIT: begin
            if (conv_valid_out)   state_d = layer_from(en_q, FROM_POOL);
            else if (tmo_expired) begin
               state_d    = ERR;
               error_d    = 1'b1;
               err_code_d = ERR_CONV;
            end
         end
         POOL_START: state_d = POOL_WAIT;
         POOL_WAIT: begin
            if (pool_valid_out) begin
               if (ch_q == count_q - 8'd1) state_d = layer_from(en_q, FROM_FC);
               else begin
                  ch_d    = ch_q + 8'd1;
                  state_d = POOL_START;
               end
            end else if (tmo_expired) begin
               state_d    = ERR;
               error_d    = 1'b1;
               err_code_d = ERR_POOL;
            end
         end
         FC_RUN: begin
            if (fc_valid)         state_d = DONE;
            else if (tmo_expired) begin
               state_d    = ERR;
               error_d    = 1'b1;
               err_code_d = ERR_FC;
            end
         end
         DONE:    state_d = IDLE;
         ERR:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (abort && state_q != IDLE) begin
         state_d    = IDLE;
         ch_d       = ch_q;
         error_d    = error_q;
         err_code_d = err_code_q;
      end
   end

   // State and run-context registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         en_q       <= '0;
         count_q    <= 8'd1;
         ch_q       <= '0;
         error_q    <= 1'b0;
         err_code_q <= ERR_NONE;
      end else begin
         state_q    <= state_d;
         en_q       <= en_d;
         count_q    <= count_d;
         ch_q       <= ch_d;
         error_q    <= error_d;
         err_code_q <= err_code_d;
      end
   end

   assign conv_valid_in = (state_q == CONV_START);
   assign pool_valid_in = (state_q == POOL_START);
   assign fc_en         = (state_q == FC_RUN);
   assign done          = (state_q == DONE);
   assign busy          = (state_q != IDLE) && (state_q != DONE);
   assign ch_idx        = ch_q;
   assign error         = error_q;
   assign err_code      = err_code_q;
   assign state_o       = state_q;
   // A completion swallowed by abort is not a result, so it is not captured
   assign pool_capture  = pool_valid_out && (state_q == POOL_WAIT) && !abort;

endmodule
